// File: rtl/reg_file_scanner.sv
// reg_file_scanner: walks every entry of a 2^D x W single-port register file in
// address order. Dump mode streams entries out over valid/ready; restore mode
// writes an incoming stream back into the file.
// Optional feature macro: REG_FILE_SCANNER_RESTORE_EN enables the restore path.
// Without it every start performs a dump and the write-side outputs are tied to 0.
module reg_file_scanner #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] rf_addr,
  output logic         rf_write_en,
  output logic [W-1:0] rf_wdata,
  input  logic [W-1:0] rf_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data
);

  localparam logic [D-1:0] IdxLast = {D{1'b1}};
  localparam logic [D-1:0] IdxOne  = {{(D-1){1'b0}}, 1'b1};

  // The state itself carries the latched mode: StDump vs StRestore.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDump    = 2'd1,
`ifdef REG_FILE_SCANNER_RESTORE_EN
    StRestore = 2'd2,
`endif
    StDone    = 2'd3
  } state_e;

  state_e       state;
  logic [D-1:0] idx;

`ifdef REG_FILE_SCANNER_RESTORE_EN
  logic in_ready_q;
`else
  // Inputs that only feed the restore path when it is built in.
  logic unused_restore_inputs;
  assign unused_restore_inputs = ^{mode, in_valid, in_data};
`endif

  // Scan sequencer: state, entry index and registered status/handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
`ifdef REG_FILE_SCANNER_RESTORE_EN
      in_ready_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          idx <= '0;
          if (start) begin
            busy <= 1'b1;
`ifdef REG_FILE_SCANNER_RESTORE_EN
            if (mode) begin
              state      <= StRestore;
              in_ready_q <= 1'b1;
            end else
`endif
            begin
              state     <= StDump;
              out_valid <= 1'b1;
            end
          end
        end
        StDump: begin
          if (out_ready) begin
            if (idx == IdxLast) begin
              state     <= StDone;
              idx       <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= idx + IdxOne;
            end
          end
        end
`ifdef REG_FILE_SCANNER_RESTORE_EN
        StRestore: begin
          if (in_valid) begin
            if (idx == IdxLast) begin
              state      <= StDone;
              idx        <= '0;
              in_ready_q <= 1'b0;
              done       <= 1'b1;
            end else begin
              idx <= idx + IdxOne;
            end
          end
        end
`endif
        StDone: begin
          state <= StIdle;
          idx   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= StIdle;
          idx       <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
`ifdef REG_FILE_SCANNER_RESTORE_EN
          in_ready_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Data paths are combinational so a read or write lands on the current idx.
  always_comb begin
    rf_addr  = idx;
    out_data = out_valid ? rf_rdata : '0;
    out_addr = out_valid ? idx : '0;
`ifdef REG_FILE_SCANNER_RESTORE_EN
    in_ready    = in_ready_q;
    rf_write_en = in_ready_q & in_valid;
    rf_wdata    = in_ready_q ? in_data : '0;
`else
    in_ready    = 1'b0;
    rf_write_en = 1'b0;
    rf_wdata    = '0;
`endif
  end

endmodule
